// File: rtl/lvds_rx_checker.sv
// Per-lane DDR capture equivalent to IDDRE1 (SAME_EDGE_PIPELINED, ULTRASCALE_PLUS, C not inverted).
// Latency: q1/q2 present together one rising edge after the rising-edge sample.
// Backpressure: none, free-running capture.
module lvds_iddr_lane (
    input  logic c,
    input  logic r,
    input  logic d,
    output logic q1,
    output logic q2
);
    logic rise_s;
    logic fall_s;

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            rise_s <= 1'b0;
            q1     <= 1'b0;
            q2     <= 1'b0;
        end else begin
            rise_s <= d;
            q1     <= rise_s;
            q2     <= fall_s;
        end
    end

    // The falling-edge sample is realigned onto the rising edge via q2.
    always_ff @(negedge c or posedge r) begin
        if (r) fall_s <= 1'b0;
        else   fall_s <= d;
    end
endmodule

// LVDS DDR receiver with incrementing-pattern lock checker (HUNT/LOCK) and error counting.
// Latency: rx_data 3 clk after even bits sampled; err_pulse/locked one clk after rx_data.
// Backpressure: none, one byte accepted every clk.
module lvds_rx_checker #(
    parameter int LANES       = 4,
    parameter int LOCK_COUNT  = 16,
    parameter int UNLOCK_ERRS = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [LANES-1:0]     d_in,
    input  logic                 clear_errs,
    output logic [2*LANES-1:0]   rx_data,
    output logic                 rx_valid,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [31:0]          err_count
);
    localparam int W  = 2 * LANES;
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int CW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [0:0] {HUNT, LOCK} state_t;

    logic             iddr_rst;
    logic [LANES-1:0] q_rise;
    logic [LANES-1:0] q_fall;
    logic [W-1:0]     byte_asm;
    logic [W-1:0]     byte_s1;
    logic [1:0]       vld_sr;
    state_t           state;
    logic [MW-1:0]    match_cnt;
    logic [CW-1:0]    cons_cnt;
    logic [W-1:0]     prev_data;
    logic [W-1:0]     expected;

    assign iddr_rst = ~resetn;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lvds_iddr_lane u_iddr (
            .c  (clk),
            .r  (iddr_rst),
            .d  (d_in[i]),
            .q1 (q_rise[i]),
            .q2 (q_fall[i])
        );
    end

    always_comb begin
        byte_asm = '0;
        for (int i = 0; i < LANES; i++) begin
            byte_asm[2*i]   = q_rise[i];
            byte_asm[2*i+1] = q_fall[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_s1  <= '0;
            rx_data  <= '0;
            vld_sr   <= '0;
            rx_valid <= 1'b0;
        end else begin
            byte_s1  <= byte_asm;
            rx_data  <= byte_s1;
            vld_sr   <= {vld_sr[0], 1'b1};
            rx_valid <= vld_sr[1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= HUNT;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            match_cnt <= '0;
            cons_cnt  <= '0;
            prev_data <= '0;
            expected  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (rx_valid) begin
                prev_data <= rx_data;
                case (state)
                    HUNT: begin
                        if (rx_data == prev_data + W'(1)) begin
                            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                                state     <= LOCK;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                expected  <= rx_data + W'(1);
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCK: begin
                        // Expected free-runs: a corrupted byte never resynchronises it.
                        expected <= expected + W'(1);
                        if (rx_data != expected) begin
                            err_pulse <= 1'b1;
                            if (err_count != '1) err_count <= err_count + 32'd1;
                            if (cons_cnt == CW'(UNLOCK_ERRS - 1)) begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                match_cnt <= '0;
                                cons_cnt  <= '0;
                            end else begin
                                cons_cnt <= cons_cnt + CW'(1);
                            end
                        end else begin
                            cons_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
            if (clear_errs) err_count <= '0;
        end
    end
endmodule

// File: tb/tb_lvds_rx_checker.sv
// Directed/randomised bench for lvds_rx_checker against a byte-stream reference model.
module tb_lvds_rx_checker;
    localparam int LANES       = 4;
    localparam int W           = 2 * LANES;
    localparam int LOCK_COUNT  = 16;
    localparam int UNLOCK_ERRS = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic [LANES-1:0] d_in;
    logic             clear_errs;
    logic [W-1:0]     rx_data;
    logic             rx_valid;
    logic             locked;
    logic             err_pulse;
    logic [31:0]      err_count;

    int n_checks = 0;
    int n_fail   = 0;

    lvds_rx_checker #(
        .LANES       (LANES),
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_ERRS (UNLOCK_ERRS)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .d_in       (d_in),
        .clear_errs (clear_errs),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Reference model: bytes on the wire flow through a 3-deep queue, the checker
    // rules are then applied to each received byte in arrival order.
    logic [W-1:0]  pipe[$];
    logic [W-1:0]  m_rx;
    logic [W-1:0]  m_prev;
    logic [W-1:0]  m_exp;
    logic [31:0]   m_err;
    bit            m_vld;
    bit            m_locked;
    bit            m_pulse;
    int            m_edges;
    int            m_match;
    int            m_cons;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pipe     = {W'(0), W'(0), W'(0)};
        m_rx     = '0;
        m_prev   = '0;
        m_exp    = '0;
        m_err    = '0;
        m_vld    = 0;
        m_locked = 0;
        m_pulse  = 0;
        m_edges  = 0;
        m_match  = 0;
        m_cons   = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] sent, input bit clr);
        m_pulse = 0;
        if (m_vld) begin
            if (!m_locked) begin
                if (m_rx == W'(m_prev + 1)) begin
                    m_match++;
                    if (m_match == LOCK_COUNT) begin
                        m_locked = 1;
                        m_match  = 0;
                        m_exp    = W'(m_rx + 1);
                    end
                end else begin
                    m_match = 0;
                end
            end else begin
                if (m_rx != m_exp) begin
                    m_pulse = 1;
                    if (m_err != 32'hFFFF_FFFF) m_err++;
                    m_cons++;
                    if (m_cons == UNLOCK_ERRS) begin
                        m_locked = 0;
                        m_match  = 0;
                        m_cons   = 0;
                    end
                end else begin
                    m_cons = 0;
                end
                m_exp = W'(m_exp + 1);
            end
            m_prev = m_rx;
        end
        if (clr) m_err = '0;
        pipe.push_back(sent);
        m_rx = pipe.pop_front();
        m_edges++;
        m_vld = (m_edges >= 3);
    endtask

    function automatic logic [LANES-1:0] lanes_of(input logic [W-1:0] b, input bit odd);
        logic [LANES-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i] = b[2*i + (odd ? 1 : 0)];
        return r;
    endfunction

    // Entered and left at negedge+2: even bits straddle the rising edge,
    // odd bits straddle the following falling edge.
    task automatic cycle(input logic [W-1:0] b, input bit clr = 0);
        d_in       = lanes_of(b, 0);
        clear_errs = clr;
        @(posedge clk);
        model_edge(b, clr);
        #1;
        chk("rx_data",   32'(rx_data),   32'(m_rx));
        chk("rx_valid",  32'(rx_valid),  32'(m_vld));
        chk("locked",    32'(locked),    32'(m_locked));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("err_count", err_count,      m_err);
        #1;
        d_in       = lanes_of(b, 1);
        clear_errs = 1'b0;
        @(negedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rx_data"},   32'(rx_data),   32'd0);
        chk({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
        chk({tag, "_locked"},    32'(locked),    32'd0);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        chk({tag, "_err_count"}, err_count,      32'd0);
    endtask

    initial begin
        logic [W-1:0] tx;
        logic [W-1:0] r;
        logic [W-1:0] bad;
        int           lock_at;
        int           pulses;

        resetn     = 1'b0;
        clear_errs = 1'b0;
        d_in       = LANES'($urandom);
        repeat (3) @(negedge clk);
        #2;
        check_zero("reset");

        model_reset();
        resetn = 1'b1;
        r = '0;
        for (int k = 0; k < 20; k++) begin
            r = W'($urandom);
            cycle(r);
        end

        // 15 good increments then a bad byte: must not lock; 16 fresh ones relock.
        tx = W'(r + 2);
        for (int k = 0; k < 16; k++) cycle(W'(tx + k));
        bad = W'(tx + 16 + 7);
        cycle(bad);
        lock_at = -1;
        for (int j = 0; j < 40; j++) begin
            cycle(W'(bad + 1 + j));
            if (locked && lock_at < 0) lock_at = j;
        end
        chk("hunt_relock_cycle", 32'(lock_at), 32'd19);
        tx = W'(bad + 41);

        // Long clean run across several 0xFF->0x00 wraps.
        for (int k = 0; k < 800; k++) begin
            cycle(tx);
            tx++;
        end
        chk("clean_err_count", err_count, 32'd0);
        chk("clean_locked", 32'(locked), 32'd1);

        // Rising sample of lane 0 stuck low: only odd expected bytes miss.
        for (int k = 0; k < 10; k++) begin
            cycle(tx & ~W'(1));
            tx++;
        end
        for (int k = 0; k < 4; k++) begin
            cycle(tx);
            tx++;
        end
        chk("stuck_err_count", err_count, 32'd5);
        chk("stuck_locked", 32'(locked), 32'd1);

        // Clear concurrent with a mismatch.
        cycle(tx ^ W'($urandom_range(1, 255)));
        tx++;
        for (int k = 0; k < 3; k++) begin
            cycle(tx);
            tx++;
        end
        cycle(tx, 1'b1);
        tx++;
        chk("clear_err_count", err_count, 32'd0);
        chk("clear_err_pulse", 32'(err_pulse), 32'd1);

        // 0x40 sent as 0x41: a single error, then expected stays in step.
        for (int k = 0; k < 256 && tx != 8'h40; k++) begin
            cycle(tx);
            tx++;
        end
        cycle(8'h41);
        tx = 8'h41;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(tx);
            tx++;
            if (err_pulse) pulses++;
        end
        chk("single_pulses", 32'(pulses), 32'd1);
        chk("single_err_count", err_count, 32'd1);
        chk("single_locked", 32'(locked), 32'd1);

        // All-zero input forces consecutive errors and unlock.
        for (int k = 0; k < 8; k++) begin
            cycle('0);
            tx++;
        end
        chk("zero_unlock", 32'(locked), 32'd0);
        lock_at = -1;
        for (int j = 0; j < 40; j++) begin
            cycle(tx);
            tx++;
            if (locked && lock_at < 0) lock_at = j;
        end
        chk("zero_relock_cycle", 32'(lock_at), 32'd20);

        // Asynchronous reset between edges while locked.
        #2;
        resetn = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        #2;
        model_reset();
        resetn = 1'b1;
        tx = 8'h10;
        lock_at = -1;
        for (int j = 1; j <= 30; j++) begin
            cycle(tx);
            tx++;
            if (j <= 3) chk("valid_after_release", 32'(rx_valid), 32'(j == 3));
            if (locked && lock_at < 0) lock_at = j;
        end
        chk("post_reset_lock_cycle", 32'(lock_at), 32'd21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lvds_rx_checker.md
LVDS_RX_CHECKER -- requirements
Module: lvds_rx_checker

Interface
REQ-001 SHALL have parameter LANES, default 4, number of DDR input lanes; byte width is 2*LANES.
REQ-002 SHALL have parameter LOCK_COUNT, default 16, consecutive good increments required to lock.
REQ-003 SHALL have parameter UNLOCK_ERRS, default 4, consecutive mismatches in LOCK that force relock.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port d_in  input  LANES  DDR data lanes, one bit per clk edge per lane.
REQ-007 SHALL have port clear_errs  input  1  synchronous clear of err_count.
REQ-008 SHALL have port rx_data  output  2*LANES  reassembled byte.
REQ-009 SHALL have port rx_valid  output  1  rx_data meaningful.
REQ-010 SHALL have port locked  output  1  checker in LOCK state.
REQ-011 SHALL have port err_pulse  output  1  one-cycle strobe per mismatched byte in LOCK.
REQ-012 SHALL have port err_count  output  32  total mismatches since reset/clear.

Function
REQ-013 SHALL capture each lane with one IDDRE1 per lane, SAME_EDGE_PIPELINED, ULTRASCALE_PLUS, C not inverted.
REQ-014 SHALL map rising-edge sample of lane i to rx_data[2i], falling-edge sample (same cycle) to rx_data[2i+1].
REQ-015 SHALL present a byte on rx_data exactly 3 clk cycles after the rising edge on which its even bits were driven.
REQ-016 SHALL assert rx_valid on the 3rd clk edge after resetn deassertion and hold it high until reset.
REQ-017 SHALL evaluate checker only on cycles with rx_valid=1; expected value is previous byte +1 mod 2^(2*LANES), 0xFF->0x00 counts as match.
REQ-018 SHALL implement states HUNT and LOCK.
REQ-019 HUNT: match -> match counter +1; mismatch -> match counter =0; counter reaching LOCK_COUNT -> LOCK next cycle, expected seeded with rx_data+1.
REQ-020 LOCK: expected advances +1 every valid cycle regardless of compare result (free-running, no resync on error).
REQ-021 LOCK mismatch: err_pulse=1 that cycle (registered, 1 cycle after rx_data), err_count +1, consecutive-error counter +1.
REQ-022 LOCK match: consecutive-error counter =0.
REQ-023 Consecutive-error counter reaching UNLOCK_ERRS -> HUNT, match counter =0, consecutive counter =0; locked falls same edge.
REQ-024 err_count SHALL saturate at 0xFFFFFFFF.
REQ-025 clear_errs SHALL zero err_count next edge; clear concurrent with mismatch gives err_count=0 (clear wins), err_pulse still asserted.
REQ-026 HUNT mismatches SHALL NOT assert err_pulse or count.
REQ-027 locked SHALL equal (state==LOCK), registered.

Reset
REQ-028 resetn=0 SHALL asynchronously force: state HUNT, rx_data 0, rx_valid 0, locked 0, err_pulse 0, err_count 0, all internal counters 0; IDDRE1 R tied to ~resetn.
REQ-029 Reset asserted mid-LOCK SHALL drop locked immediately; after release block relocks only via full HUNT sequence.

Verification
REQ-030 Tx drives 8-bit incrementing count from 0 via 4 ODDRE1 lanes (bit 2i rising, 2i+1 falling) -> rx_data reproduces count, latency 3, locked rises after 16 matching increments, err_count stays 0 through ≥3 wraps 0xFF->0x00.
REQ-031 While locked, corrupt one byte (0x40 sent as 0x41) -> single err_pulse, err_count=1, locked stays 1, next byte 0x41 matches (free-running expected).
REQ-032 While locked, stuck lane 0 low for 10 cycles -> err_count increments on each odd-valued expected byte; 4 consecutive errors (force all-zero input) -> locked=0, then relock 16 good bytes after pattern restored.
REQ-033 In HUNT, feed 15 good increments then one bad -> locked stays 0, needs 16 fresh increments to lock.
REQ-034 Assert clear_errs on same cycle as a mismatch with err_count=5 -> err_count=0, err_pulse=1.
REQ-035 Assert resetn=0 asynchronously mid-LOCK between clk edges -> all outputs 0 immediately; rx_valid returns 3 edges after release.
